// File: rtl/mor1kx_cache_pkg.sv
// Shared icache refill definitions: one-hot FSM states and line geometry.
// Helpers derive words per line and the word index inside a line.
package mor1kx_cache_pkg;

  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_BURST = 3'b010;
  localparam logic [2:0] S_DONE  = 3'b100;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    BURST = S_BURST,
    DONE  = S_DONE
  } refill_state_t;

  function automatic int words_per_line(input int bw);
    return 1 << (bw - 2);
  endfunction

  function automatic int unsigned line_idx(
    input logic [31:0] adr,
    input int          bw
  );
    return (adr >> 2) & ((32'd1 << (bw - 2)) - 32'd1);
  endfunction

endpackage

// File: rtl/mor1kx_bus_watchdog.sv
// Saturating no-ack counter; expired holds while the count is all-ones.
// Clear has priority over enable.
module mor1kx_bus_watchdog #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WIDTH-1:0] cnt_q;

  assign expired = &cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mor1kx_icache_refill_ctrl.sv
// Icache line refill sequencer: one ibus burst per miss, bus error/timeout abort.
// Define MOR1KX_ICACHE_CRITICAL_WORD_FIRST_EN to fetch the missed word first.
module mor1kx_icache_refill_ctrl
  import mor1kx_cache_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH      = 32,
  parameter int OPTION_ICACHE_BLOCK_WIDTH = 5,
  parameter int OPTION_ICACHE_LIMIT_WIDTH = 32,
  parameter int TIMEOUT_WIDTH             = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            refill_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
  input  logic                            refill_done_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] ic_wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ic_wrdat_o,
  output logic                            ic_we_o,
  output logic                            ic_imem_err_o,
  output logic                            ibus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
  output logic                            ibus_burst_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_dat_i,
  input  logic                            ibus_ack_i,
  input  logic                            ibus_err_i,
  output logic                            busy_o
);

  localparam int OW    = OPTION_OPERAND_WIDTH;
  localparam int BW    = OPTION_ICACHE_BLOCK_WIDTH;
  localparam int LIM   = OPTION_ICACHE_LIMIT_WIDTH;
  localparam int WORDS = words_per_line(BW);
  localparam int IW    = BW - 2;
  localparam int TW    = OW - BW;

  localparam logic [OW-1:0] CMASK =
    (LIM >= OW) ? '1 : OW'((64'd1 << LIM) - 64'd1);

  refill_state_t   state;
  logic [TW-1:0]   base_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   cnt_q;
  logic [IW-1:0]   start_idx;
  logic [OW-1:0]   line_adr;
  logic [OW-1:0]   cur_adr;
  logic            in_burst;
  logic            last;
  logic            expired;
  logic            beat_err;
  logic            beat_ok;
  logic            adr_unused;

`ifdef MOR1KX_ICACHE_CRITICAL_WORD_FIRST_EN
  assign start_idx = IW'(line_idx(refill_adr_i, BW));
`else
  assign start_idx = '0;
`endif

  assign adr_unused = ^refill_adr_i[BW-1:0];

  assign in_burst = state[1];
  assign last     = cnt_q == IW'(WORDS - 1);
  assign beat_err = in_burst & (ibus_err_i | expired);
  assign beat_ok  = in_burst & ibus_ack_i & ~beat_err;

  // Bits above the cacheable limit bypass the line logic untouched.
  assign line_adr = {base_q, idx_q, 2'b00};
  assign cur_adr  = (line_adr & CMASK) | (line_adr & ~CMASK);

  assign ibus_req_o    = in_burst;
  assign ibus_adr_o    = in_burst ? cur_adr : '0;
  assign ibus_burst_o  = in_burst & ~last;
  assign ic_we_o       = beat_ok;
  assign ic_wradr_o    = beat_ok ? cur_adr : '0;
  assign ic_wrdat_o    = beat_ok ? ibus_dat_i : '0;
  assign ic_imem_err_o = beat_err;
  assign busy_o        = ~state[0];

  mor1kx_bus_watchdog #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (~in_burst | beat_ok),
    .enable  (in_burst & ~ibus_ack_i),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      base_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (1'b1)
        state[0]: begin
          if (refill_req_i) begin
            base_q <= refill_adr_i[OW-1:BW];
            idx_q  <= start_idx;
            cnt_q  <= '0;
            state  <= BURST;
          end
        end
        state[1]: begin
          if (beat_err) begin
            state <= DONE;
          end else if (beat_ok) begin
            idx_q <= idx_q + IW'(1);
            cnt_q <= cnt_q + IW'(1);
            if (last) state <= DONE;
          end
        end
        state[2]: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // The icache must see its own last word on the final beat.
  assert property (@(posedge clk) disable iff (!rst_n)
    (beat_ok && last) |-> refill_done_i);

endmodule

// File: tb/tb_mor1kx_icache_refill_ctrl.sv
// Bench for the icache refill sequencer: vector table plus write scoreboard.
// Honours MOR1KX_ICACHE_CRITICAL_WORD_FIRST_EN for expected word order.
module tb_mor1kx_icache_refill_ctrl;

`ifdef MOR1KX_ICACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  localparam int WORDS = 8;

  typedef struct {
    logic [31:0] adr;
    int          err_beat;
    bit          err_ack;
    int          rst_beat;
    bit          tmo;
    bit          gap;
    int          exp_we;
    int          exp_err;
    int          exp_busy;
  } vec_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        refill_req;
  logic [31:0] refill_adr;
  logic        refill_done;
  logic [31:0] ic_wradr;
  logic [31:0] ic_wrdat;
  logic        ic_we;
  logic        ic_err;
  logic        ibus_req;
  logic [31:0] ibus_adr;
  logic        ibus_burst;
  logic [31:0] ibus_dat;
  logic        ibus_ack;
  logic        ibus_err;
  logic        busy;
  logic [2:0]  last_w;

  wr_t  exp_q[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;

  mor1kx_icache_refill_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .refill_req_i  (refill_req),
    .refill_adr_i  (refill_adr),
    .refill_done_i (refill_done),
    .ic_wradr_o    (ic_wradr),
    .ic_wrdat_o    (ic_wrdat),
    .ic_we_o       (ic_we),
    .ic_imem_err_o (ic_err),
    .ibus_req_o    (ibus_req),
    .ibus_adr_o    (ibus_adr),
    .ibus_burst_o  (ibus_burst),
    .ibus_dat_i    (ibus_dat),
    .ibus_ack_i    (ibus_ack),
    .ibus_err_i    (ibus_err),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Icache model: it knows the last word is the one before the first.
  assign refill_done = ic_we & (ic_wradr[4:2] == last_w);

  function automatic logic [31:0] bus_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic outs_any();
    return |{ic_wradr, ic_wrdat, ic_we, ic_err,
             ibus_req, ibus_adr, ibus_burst, busy};
  endfunction

  task automatic run_refill(input vec_t v, input bit hold);
    int          start, beat, nwe, npulse, nbusy, pulse_at, rst_phase;
    bit          started, fin, prev_end;
    logic [31:0] a;
    wr_t         w;
    start = CWF ? int'(v.adr[4:2]) : 0;
    last_w = 3'(start + WORDS - 1);
    for (int k = 0; k < v.exp_we; k++) begin
      a = {v.adr[31:5], 3'(start + k), 2'b00};
      w.adr = a;
      w.dat = bus_data(a);
      exp_q.push_back(w);
    end
    beat = 0; nwe = 0; npulse = 0; nbusy = 0;
    pulse_at = 0; rst_phase = 0;
    started = 1'b0; fin = 1'b0; prev_end = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(posedge clk);
      #1;
      if (v.rst_beat >= 0 && beat == v.rst_beat && rst_phase == 0)
        rst_phase = 1;
      if (rst_phase == 3) begin
        rst_n = 1'b1;
        ibus_ack = 1'b0;
        fin = 1'b1;
        break;
      end
      if (rst_phase > 0) begin
        rst_n = 1'b0;
        refill_req = 1'b0;
        ibus_ack = 1'b1;
        ibus_err = 1'b0;
        ibus_dat = 32'hFFFF_FFFF;
      end else begin
        refill_req = !started || hold;
        refill_adr = v.adr;
        ibus_ack = 1'b0;
        ibus_err = 1'b0;
        if (ibus_req && !v.tmo) begin
          if (beat == v.err_beat) begin
            ibus_err = 1'b1;
            ibus_ack = v.err_ack;
          end else begin
            ibus_ack = !v.gap || (cyc % 2 == 1);
          end
        end
        ibus_dat = bus_data(ibus_adr);
      end
      @(negedge clk);
      if (rst_phase > 0) begin
        chk("reset_outputs_zero", {31'b0, outs_any()}, 32'h0);
        rst_phase++;
        continue;
      end
      if (busy) begin
        started = 1'b1;
        nbusy++;
      end
      if (prev_end) begin
        chk("done_cycle_req_busy", {30'b0, ibus_req, busy}, 32'h1);
        prev_end = 1'b0;
      end
      if (ibus_req && beat < WORDS) begin
        chk("ibus_adr", ibus_adr, {v.adr[31:5], 3'(start + beat), 2'b00});
        chk("ibus_burst", 32'(ibus_burst), 32'(beat != WORDS - 1));
      end
      if (ic_we) begin
        nwe++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: adr %h, expected no write",
                   ic_wradr);
        end else begin
          w = exp_q.pop_front();
          chk("ic_wradr", ic_wradr, w.adr);
          chk("ic_wrdat", ic_wrdat, w.dat);
        end
        if (beat == WORDS - 1) prev_end = 1'b1;
      end
      if (ic_err) begin
        npulse++;
        pulse_at = nbusy;
        prev_end = 1'b1;
      end
      if (ibus_req && (ibus_ack || ibus_err)) beat++;
      if (started && !busy) fin = 1'b1;
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL refill_timeout: busy %0b after 400 cycles, expected 0",
               busy);
    end
    chk("write_count", 32'(nwe), 32'(v.exp_we));
    chk("err_pulses", 32'(npulse), 32'(v.exp_err));
    if (v.exp_busy > 0) chk("busy_cycles", 32'(nbusy), 32'(v.exp_busy));
    if (v.tmo) chk("timeout_cycle", 32'(pulse_at), 32'd256);
    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (!hold) refill_req = 1'b0;
    ibus_ack = 1'b0;
    ibus_err = 1'b0;
  endtask

  initial begin
    vec_t hv;
    vecs[0] = '{32'h1000_0014, -1, 1'b0, -1, 1'b0, 1'b0, 8, 0, 9};
    vecs[1] = '{32'h2000_0000, -1, 1'b0, -1, 1'b0, 1'b0, 8, 0, 9};
    vecs[2] = '{32'h1000_001C, -1, 1'b0, -1, 1'b0, 1'b0, 8, 0, 9};
    vecs[3] = '{32'h1000_0008,  2, 1'b0, -1, 1'b0, 1'b0, 2, 1, 4};
    vecs[4] = '{32'h6000_0004,  0, 1'b1, -1, 1'b0, 1'b0, 0, 1, 2};
    vecs[5] = '{32'h3000_0040, -1, 1'b0, -1, 1'b1, 1'b0, 0, 1, 257};
    vecs[6] = '{32'h1000_0034, -1, 1'b0,  4, 1'b0, 1'b0, 4, 0, 0};
    vecs[7] = '{32'h4000_0010, -1, 1'b0, -1, 1'b0, 1'b0, 8, 0, 9};
    vecs[8] = '{32'h5000_000C, -1, 1'b0, -1, 1'b0, 1'b1, 8, 0, 16};

    rst_n = 1'b0;
    refill_req = 1'b1;
    refill_adr = 32'h1234_5678;
    ibus_dat = 32'hDEAD_BEEF;
    ibus_ack = 1'b1;
    ibus_err = 1'b0;
    last_w = 3'd7;
    repeat (2) begin
      @(negedge clk);
      chk("reset_state", {31'b0, outs_any()}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    refill_req = 1'b0;
    ibus_ack = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {31'b0, outs_any()}, 32'h0);

    for (int i = 0; i < 9; i++) run_refill(vecs[i], 1'b0);

    hv = vecs[0];
    hv.adr = 32'h7000_0018;
    run_refill(hv, 1'b1);
    @(posedge clk);
    #1;
    ibus_ack = 1'b0;
    @(negedge clk);
    chk("restart_req", {31'b0, ibus_req}, 32'h1);
    chk("restart_adr", ibus_adr,
        {hv.adr[31:5], (CWF ? hv.adr[4:2] : 3'd0), 2'b00});
    run_refill(hv, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
